// File: rtl/ps2_key_event_queue_pkg.sv
// Shared definitions for the PS/2 key event queue.
//   - Bit positions of the 24-bit queue entry.
//   - Set-2 scancodes of the modifier keys and of the keys with fixed ASCII codes.
//   - Modifier state record used by the queue top.
package ps2_key_event_queue_pkg;

    localparam int ENTRY_W = 24;

    // Entry layout: {scancode, released, extended, shift, ctrl, alt, caps, 2'b00, ascii}
    localparam int F_CODE_MSB  = 23;
    localparam int F_CODE_LSB  = 16;
    localparam int F_RELEASED  = 15;
    localparam int F_EXTENDED  = 14;
    localparam int F_SHIFT     = 13;
    localparam int F_CTRL      = 12;
    localparam int F_ALT       = 11;
    localparam int F_CAPS      = 10;
    localparam int F_ASCII_MSB = 7;
    localparam int F_ASCII_LSB = 0;

    // Modifier keys
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Keys with a fixed ASCII code
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] SC_TAB      = 8'h0D;
    localparam logic [7:0] SC_ESC      = 8'h76;
    localparam logic [7:0] SC_SPACE    = 8'h29;
    localparam logic [7:0] SC_KP_SLASH = 8'h4A;

    typedef struct packed {
        logic lshift;
        logic rshift;
        logic ctrl;
        logic alt;
        logic caps;
    } mod_state_t;

endpackage

// File: rtl/ps2_set2_to_ascii.sv
// Combinational set-2 scancode to ASCII translation (US layout).
// Ports:
//   scancode [7:0] : set-2 code, prefixes already stripped
//   extended       : 1 = E0-prefixed key
//   shift/ctrl/caps: modifier state to apply
//   ascii    [7:0] : translated character, 0 when the key has no translation
module ps2_set2_to_ascii
    import ps2_key_event_queue_pkg::*;
(
    input  logic [7:0] scancode,
    input  logic       extended,
    input  logic       shift,
    input  logic       ctrl,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [4:0] letter;   // 1..26 for a..z, 0 when not a letter
    logic [7:0] plain;    // character without shift
    logic [7:0] shifted;  // character with shift

    always_comb begin
        letter  = 5'd0;
        plain   = 8'h00;
        shifted = 8'h00;
        case (scancode)
            8'h1C: letter = 5'd1;
            8'h32: letter = 5'd2;
            8'h21: letter = 5'd3;
            8'h23: letter = 5'd4;
            8'h24: letter = 5'd5;
            8'h2B: letter = 5'd6;
            8'h34: letter = 5'd7;
            8'h33: letter = 5'd8;
            8'h43: letter = 5'd9;
            8'h3B: letter = 5'd10;
            8'h42: letter = 5'd11;
            8'h4B: letter = 5'd12;
            8'h3A: letter = 5'd13;
            8'h31: letter = 5'd14;
            8'h44: letter = 5'd15;
            8'h4D: letter = 5'd16;
            8'h15: letter = 5'd17;
            8'h2D: letter = 5'd18;
            8'h1B: letter = 5'd19;
            8'h2C: letter = 5'd20;
            8'h3C: letter = 5'd21;
            8'h2A: letter = 5'd22;
            8'h1D: letter = 5'd23;
            8'h22: letter = 5'd24;
            8'h35: letter = 5'd25;
            8'h1A: letter = 5'd26;
            8'h16: begin plain = 8'h31; shifted = 8'h21; end  // 1 !
            8'h1E: begin plain = 8'h32; shifted = 8'h40; end  // 2 @
            8'h26: begin plain = 8'h33; shifted = 8'h23; end  // 3 #
            8'h25: begin plain = 8'h34; shifted = 8'h24; end  // 4 $
            8'h2E: begin plain = 8'h35; shifted = 8'h25; end  // 5 %
            8'h36: begin plain = 8'h36; shifted = 8'h5E; end  // 6 ^
            8'h3D: begin plain = 8'h37; shifted = 8'h26; end  // 7 &
            8'h3E: begin plain = 8'h38; shifted = 8'h2A; end  // 8 *
            8'h46: begin plain = 8'h39; shifted = 8'h28; end  // 9 (
            8'h45: begin plain = 8'h30; shifted = 8'h29; end  // 0 )
            8'h0E: begin plain = 8'h60; shifted = 8'h7E; end  // ` ~
            8'h4E: begin plain = 8'h2D; shifted = 8'h5F; end  // - _
            8'h55: begin plain = 8'h3D; shifted = 8'h2B; end  // = +
            8'h54: begin plain = 8'h5B; shifted = 8'h7B; end  // [ {
            8'h5B: begin plain = 8'h5D; shifted = 8'h7D; end  // ] }
            8'h5D: begin plain = 8'h5C; shifted = 8'h7C; end  // \ |
            8'h4C: begin plain = 8'h3B; shifted = 8'h3A; end  // ; :
            8'h52: begin plain = 8'h27; shifted = 8'h22; end  // ' "
            8'h41: begin plain = 8'h2C; shifted = 8'h3C; end  // , <
            8'h49: begin plain = 8'h2E; shifted = 8'h3E; end  // . >
            8'h4A: begin plain = 8'h2F; shifted = 8'h3F; end  // / ?
            SC_ENTER: begin plain = 8'h0D; shifted = 8'h0D; end
            SC_BKSP:  begin plain = 8'h08; shifted = 8'h08; end
            SC_TAB:   begin plain = 8'h09; shifted = 8'h09; end
            SC_ESC:   begin plain = 8'h1B; shifted = 8'h1B; end
            SC_SPACE: begin plain = 8'h20; shifted = 8'h20; end
            default: ;
        endcase
    end

    always_comb begin
        ascii = 8'h00;
        if (extended) begin
            // Only keypad Enter and keypad '/' carry a character on the E0 page
            if (scancode == SC_ENTER) begin
                ascii = 8'h0D;
            end else if (scancode == SC_KP_SLASH) begin
                ascii = 8'h2F;
            end
        end else if (letter != 5'd0) begin
            // Ctrl takes priority over case and yields the control code
            if (ctrl) begin
                ascii = {3'b000, letter};
            end else if (shift ^ caps) begin
                ascii = 8'h40 + {3'b000, letter};
            end else begin
                ascii = 8'h60 + {3'b000, letter};
            end
        end else begin
            ascii = shift ? shifted : plain;
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 key event queue: tracks modifiers and caps lock, translates each key
// event to ASCII and stores it in a first-word-fall-through FIFO for the CPU.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   kb_interrupt        : one-cycle strobe, event valid on scancode/released/extended
//   rd_en               : pop the head entry (ignored when empty)
//   rd_data [23:0]      : head entry, 0 when empty
//   rd_valid, count     : FIFO not empty, current occupancy
//   overflow            : sticky dropped-event flag, cleared by clr_overflow
//   caps_lock_led       : current caps-lock state
module ps2_key_event_queue
    import ps2_key_event_queue_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter bit PUSH_RELEASES = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   kb_interrupt,
    input  logic [7:0]             scancode,
    input  logic                   released,
    input  logic                   extended,
    input  logic                   rd_en,
    output logic [ENTRY_W-1:0]     rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic                   caps_lock_led
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic               stage_valid_reg;
    logic [7:0]         stage_code_reg;
    logic               stage_rel_reg;
    logic               stage_ext_reg;
    mod_state_t         mod_reg, mod_next;
    logic               shift_now;
    logic [7:0]         ascii;
    logic [ENTRY_W-1:0] entry_next;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               overflow_reg;
    logic               push_req, pop, full, do_write, drop;

    // Input stage: the event is translated and queued one cycle after its strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_reg <= 1'b0;
            stage_code_reg  <= 8'h00;
            stage_rel_reg   <= 1'b0;
            stage_ext_reg   <= 1'b0;
        end else begin
            stage_valid_reg <= kb_interrupt;
            if (kb_interrupt) begin
                stage_code_reg <= scancode;
                stage_rel_reg  <= released;
                stage_ext_reg  <= extended;
            end
        end
    end

    assign shift_now = mod_reg.lshift | mod_reg.rshift;

    // Modifier tracking; E0 12 (fake shift) is ignored, ctrl/alt accept both pages
    always_comb begin
        mod_next = mod_reg;
        if (stage_valid_reg) begin
            if (!stage_ext_reg && stage_code_reg == SC_LSHIFT) mod_next.lshift = !stage_rel_reg;
            if (!stage_ext_reg && stage_code_reg == SC_RSHIFT) mod_next.rshift = !stage_rel_reg;
            if (stage_code_reg == SC_CTRL) mod_next.ctrl = !stage_rel_reg;
            if (stage_code_reg == SC_ALT)  mod_next.alt  = !stage_rel_reg;
            // Typematic repeats arrive as makes, so each one toggles
            if (!stage_ext_reg && !stage_rel_reg && stage_code_reg == SC_CAPS)
                mod_next.caps = !mod_reg.caps;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mod_reg <= '0;
        else        mod_reg <= mod_next;
    end

    ps2_set2_to_ascii u_xlate (
        .scancode (stage_code_reg),
        .extended (stage_ext_reg),
        .shift    (shift_now),
        .ctrl     (mod_reg.ctrl),
        .caps     (mod_reg.caps),
        .ascii    (ascii)
    );

    // Entry flags record the modifier state before this event is applied
    always_comb begin
        entry_next                          = '0;
        entry_next[F_CODE_MSB:F_CODE_LSB]   = stage_code_reg;
        entry_next[F_RELEASED]              = stage_rel_reg;
        entry_next[F_EXTENDED]              = stage_ext_reg;
        entry_next[F_SHIFT]                 = shift_now;
        entry_next[F_CTRL]                  = mod_reg.ctrl;
        entry_next[F_ALT]                   = mod_reg.alt;
        entry_next[F_CAPS]                  = mod_reg.caps;
        entry_next[F_ASCII_MSB:F_ASCII_LSB] = ascii;
    end

    assign rd_valid = (count_reg != '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign pop      = rd_en && rd_valid;
    assign push_req = stage_valid_reg && (PUSH_RELEASES || !stage_rel_reg);
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign do_write = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr_reg] <= entry_next;
    end

    always_comb begin
        case ({do_write, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_write) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)      rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            if (drop)              overflow_reg <= 1'b1;
            else if (clr_overflow) overflow_reg <= 1'b0;
        end
    end

    // Asynchronous read keeps the head visible the cycle after it is written;
    // the gate hides stale storage while empty
    assign rd_data       = rd_valid ? mem[rd_ptr_reg] : '0;
    assign count         = count_reg;
    assign overflow      = overflow_reg;
    assign caps_lock_led = mod_reg.caps;

endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
Consumes decoded key events from the PS/2 receiver (one-cycle new-key strobe, 8-bit make/break code, released flag, extended flag). Tracks modifier and caps-lock state and translates set-2 scancodes to ASCII. Queues each event in a FIFO that the CPU/I/O bus pops with a read strobe. Sits between the PS/2 port and the memory-mapped keyboard register block.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..256
PUSH_RELEASES, 1, 1 = queue break events too; 0 = break events update modifiers only and are not queued

Ports:
clk  in  1  system clock, same domain as the PS/2 receiver
rst_n  in  1  asynchronous active-low reset
kb_interrupt  in  1  one-cycle strobe: new key event valid on scancode/released/extended
scancode  in  8  set-2 code of the event, with E0/F0 prefixes already stripped
released  in  1  1 = break, 0 = make
extended  in  1  1 = E0-prefixed key
rd_en  in  1  pop strobe; ignored when rd_valid=0
rd_data  out  24  head entry: [23:16] raw scancode, [15] released, [14] extended, [13] shift, [12] ctrl, [11] alt, [10] caps_lock, [9:8] 0, [7:0] ASCII (0 = no translation)
rd_valid  out  1  FIFO not empty
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: an event was dropped
clr_overflow  in  1  clears overflow (set wins if same cycle)
caps_lock_led  out  1  current caps-lock state

Behaviour:
- Reset (async assert, sync release): FIFO empty, rd_valid=0, count=0, rd_data=0, overflow=0, all modifiers=0, caps_lock_led=0.
- Pipeline:
  - Cycle N: kb_interrupt=1; inputs captured into a stage register on the rising edge ending cycle N.
  - Cycle N+1: translation is combinational from the stage register; the FIFO write occurs on the edge ending N+1; modifiers and caps lock update on the same edge.
  - Earliest rd_valid=1 is cycle N+2. Back-to-back strobes on every cycle are accepted.
- Flag bits in an entry show modifier state before the event. Example: the shift make entry itself has shift=0.
- Modifier rules:
  - Left shift: 0x12 non-extended. Right shift: 0x59 non-extended. E0 12 is ignored.
  - ctrl: 0x14, either extended value. alt: 0x11, either extended value.
  - Each modifier is set on make and cleared on break. Shift is the OR of left and right.
  - caps_lock toggles on make of 0x58 non-extended only; break and typematic repeat makes also toggle on make only.
- ASCII translation (sub-module), non-extended keys:
  - Letters: uppercase when shift XOR caps_lock.
  - ctrl+letter gives 0x01..0x1A, overriding case.
  - Digits and US punctuation use shift-selected values, e.g. 0x16 gives '1' (0x31) or '!' (0x21).
  - Fixed codes: Enter 0x5A→0x0D, Backspace 0x66→0x08, Tab 0x0D→0x09, Esc 0x76→0x1B, Space 0x29→0x20.
- ASCII translation, extended keys: 0 except E0 5A→0x0D and E0 4A→0x2F.
- Unmapped codes produce ASCII 0.
- Break entries carry the same ASCII as the make would.
- FIFO is DEPTH entries, circular, with pointers wrapping at DEPTH.
  - Pop: rd_en with rd_valid advances the head on the next edge. rd_data is the head entry, registered/first-word-fall-through, valid whenever rd_valid=1.
  - Push and pop in the same cycle: both happen, count unchanged. This includes when full (the push is accepted) and when count=1.
  - Push when full without pop: entry dropped, overflow set, FIFO contents unchanged. Modifiers still update.
- PUSH_RELEASES=0: break events never write, but still clear modifiers.
- rd_en while empty: no effect; count never underflows.

Decomposition:
- Shared package holds:
  - entry field bit positions
  - modifier scancode constants (0x12, 0x59, 0x14, 0x11, 0x58)
  - special-key constants (0x5A, 0x66, 0x0D, 0x76, 0x29, 0x4A)
  - ENTRY_W=24
- Sub-module ps2_set2_to_ascii is purely combinational:
  - inputs: scancode, extended, shift, ctrl, caps
  - output: ascii[7:0]
- FIFO storage and pointers stay in the top module.

Test Plan:
- Reset then strobe 0x1C make (A) → cycle N+2 rd_valid=1, rd_data=0x1C_00_61, count=1; rd_en → rd_valid=0 next cycle.
- 0x12 make, 0x1C make, 0x12 break, 0x1C break → four entries, in order:
  - shift make: flags shift=0, ASCII 0
  - 'A': shift=1, ASCII 0x41
  - shift break: shift=1, released=1
  - A break: shift=0, ASCII 0x61
- 0x58 make/break, then 0x1C make → caps_lock_led=1, A entry bit10=1, ASCII 0x41. A second 0x58 make → led=0.
- ctrl (0x14) make then 0x21 (C) make → ASCII 0x03, bit12=1. Extended 0x5A → ASCII 0x0D, bit14=1.
- Fill DEPTH=16 entries, then 1 more strobe without rd_en → count=16, overflow=1, head unchanged. clr_overflow → 0. Then strobe with rd_en on its write cycle → accepted, count stays 16.
- Assert rst_n=0 mid-stream with 5 entries and shift held → immediately rd_valid=0, count=0, shift flag 0 on the next event. Also with PUSH_RELEASES=0: break strobes leave count unchanged.
